// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: front end of the vend datapath.
// Collects coins into a saturating-free credit register (overflowing coins are
// rejected), locks the credit while the downstream subtractor works, and hands
// back either the change or the whole credit through a refund handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no credit, waiting for the first valid coin
// COLLECT | accumulating coins, idle timeout running
// LOCK    | credit frozen as subtractor minuend, waiting for vend_done
// REFUND  | refund_amount offered to the dispenser until refund_ack
module coin_credit_accumulator #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         coin_valid,
  input  logic [1:0]   coin_code,
  output logic         coin_ready,
  output logic         coin_reject,
  output logic [N-1:0] credit,
  output logic [1:0]   state_o,
  input  logic         vend_req,
  input  logic         vend_done,
  input  logic [N-1:0] change_in,
  input  logic         cancel,
  output logic         refund_valid,
  output logic [N-1:0] refund_amount,
  input  logic         refund_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    LOCK    = 2'b10,
    REFUND  = 2'b11
  } state_t;

  localparam int              CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0]   TC_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [N:0]      MAX_CR  = {1'b0, {N{1'b1}}};

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [N:0]    coin_val;
  logic [N:0]    sum;
  logic          coin_take;
  logic          coin_ok;
  logic          coin_bad;
  logic          timeout_hit;

  // Ready is a pure state decode so nothing upstream sees a combinational loop.
  assign coin_ready = (state == IDLE) || (state == COLLECT);
  assign state_o    = state;

  // Coin value decode and overflow check, done one bit wider than credit.
  always_comb begin
    coin_val = '0;
    case (coin_code)
      2'b00:   coin_val = (N+1)'(1);
      2'b01:   coin_val = (N+1)'(2);
      2'b10:   coin_val = (N+1)'(5);
      default: coin_val = '0;
    endcase
  end

  assign sum         = {1'b0, credit} + coin_val;
  assign coin_take   = coin_valid && coin_ready;
  assign coin_ok     = coin_take && (coin_code != 2'b11) && (sum <= MAX_CR);
  assign coin_bad    = coin_take && !coin_ok;
  assign timeout_hit = !coin_ok && (tcnt == TC_LAST);

  // Main controller: state, credit, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit        <= '0;
      tcnt          <= '0;
      coin_reject   <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
    end else begin
      coin_reject <= coin_bad;
      case (state)
        IDLE: begin
          if (coin_ok) begin
            credit <= sum[N-1:0];
            tcnt   <= '0;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (cancel || (!vend_req && timeout_hit)) begin
            // A coin landing in the same cycle goes straight into the refund.
            refund_amount <= coin_ok ? sum[N-1:0] : credit;
            refund_valid  <= 1'b1;
            credit        <= '0;
            tcnt          <= '0;
            state         <= REFUND;
          end else if (vend_req) begin
            if (coin_ok) credit <= sum[N-1:0];
            tcnt  <= '0;
            state <= LOCK;
          end else if (coin_ok) begin
            credit <= sum[N-1:0];
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        LOCK: begin
          if (vend_done) begin
            credit <= '0;
            if (change_in != '0) begin
              refund_amount <= change_in;
              refund_valid  <= 1'b1;
              state         <= REFUND;
            end else begin
              state <= IDLE;
            end
          end
        end
        REFUND: begin
          if (refund_ack) begin
            refund_valid  <= 1'b0;
            refund_amount <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Scoreboard bench for coin_credit_accumulator: directed plan followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_coin_credit_accumulator;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int MAXC = (1 << N) - 1;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_LOCK = 2, P_REFUND = 3;

  typedef struct packed {
    logic         rdy;
    logic         rej;
    logic [1:0]   st;
    logic [N-1:0] cr;
    logic         rv;
    logic [N-1:0] ra;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         coin_valid = 1'b0;
  logic [1:0]   coin_code = 2'b00;
  logic         coin_ready;
  logic         coin_reject;
  logic [N-1:0] credit;
  logic [1:0]   state_o;
  logic         vend_req = 1'b0;
  logic         vend_done = 1'b0;
  logic [N-1:0] change_in = '0;
  logic         cancel = 1'b0;
  logic         refund_valid;
  logic [N-1:0] refund_amount;
  logic         refund_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  obs_t eq[$];
  int   rq[$];

  int m_ph = P_IDLE;
  int m_credit = 0;
  int m_ramt = 0;
  int m_last = 0;
  int m_cyc = 0;

  coin_credit_accumulator #(.N(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_ready(coin_ready), .coin_reject(coin_reject),
    .credit(credit), .state_o(state_o),
    .vend_req(vend_req), .vend_done(vend_done), .change_in(change_in),
    .cancel(cancel),
    .refund_valid(refund_valid), .refund_amount(refund_amount),
    .refund_ack(refund_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic obs_t expect_now(input bit rej);
    obs_t o;
    o.rdy = (m_ph == P_IDLE) || (m_ph == P_COLLECT);
    o.rej = rej;
    o.st  = 2'(m_ph);
    o.cr  = N'(m_credit);
    o.rv  = (m_ph == P_REFUND);
    o.ra  = N'(m_ramt);
    return o;
  endfunction

  // One clock of stimulus; the model predicts what the DUT shows after the edge.
  task automatic step(input bit cv, input bit [1:0] code, input bit vr, input bit vd,
                      input bit [N-1:0] chg, input bit cn, input bit ack);
    int  val;
    bit  take, good, bad;
    @(negedge clk);
    rst_n = 1'b1;
    coin_valid = cv; coin_code = code; vend_req = vr; vend_done = vd;
    change_in = chg; cancel = cn; refund_ack = ack;

    val  = (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : (code == 2'd2) ? 5 : 0;
    take = cv && (m_ph == P_IDLE || m_ph == P_COLLECT);
    good = take && (code != 2'd3) && (m_credit + val <= MAXC);
    bad  = take && !good;

    case (m_ph)
      P_IDLE: if (good) begin
        m_credit += val; m_ph = P_COLLECT; m_last = m_cyc;
      end
      P_COLLECT: begin
        if (cn || (!vr && !good && (m_cyc - m_last == TO))) begin
          m_ramt = m_credit + (good ? val : 0);
          rq.push_back(m_ramt);
          m_credit = 0; m_ph = P_REFUND;
        end else if (vr) begin
          if (good) m_credit += val;
          m_ph = P_LOCK;
        end else if (good) begin
          m_credit += val; m_last = m_cyc;
        end
      end
      P_LOCK: if (vd) begin
        m_credit = 0;
        if (chg != 0) begin
          m_ramt = int'(chg); rq.push_back(m_ramt); m_ph = P_REFUND;
        end else begin
          m_ph = P_IDLE;
        end
      end
      default: if (ack) begin
        m_ramt = 0; m_ph = P_IDLE;
      end
    endcase
    m_cyc++;
    eq.push_back(expect_now(bad));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    coin_valid = 0; vend_req = 0; vend_done = 0; cancel = 0; refund_ack = 0;
    change_in = '0; coin_code = 2'b00;
    m_ph = P_IDLE; m_credit = 0; m_ramt = 0; m_last = 0; m_cyc = 0;
    rq.delete();
    eq.push_back(expect_now(1'b0));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, '0, 0, 0);
  endtask

  // Monitor: per-cycle output compare plus refund handshake scoreboard.
  initial begin
    obs_t got, exp;
    logic pv;
    logic [N-1:0] pa;
    int er;
    pv = 1'b0; pa = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pv && refund_ack && rst_n) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL refund_unexpected: got amount %0d, none expected", pa);
        end else begin
          er = rq.pop_front();
          if (int'(pa) != er) begin
            errors++;
            $display("FAIL refund_amount: got %0d expected %0d", pa, er);
          end
        end
      end
      got.rdy = coin_ready; got.rej = coin_reject; got.st = state_o;
      got.cr = credit; got.rv = refund_valid; got.ra = refund_amount;
      if (eq.size() > 0) begin
        exp = eq.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs @%0t: got rdy=%b rej=%b st=%0d cr=%0d rv=%b ra=%0d expected rdy=%b rej=%b st=%0d cr=%0d rv=%b ra=%0d",
                   $time, got.rdy, got.rej, got.st, got.cr, got.rv, got.ra,
                   exp.rdy, exp.rej, exp.st, exp.cr, exp.rv, exp.ra);
        end
      end
      pv = refund_valid; pa = refund_amount;
    end
  end

  initial begin
    int pc;
    repeat (2) @(negedge clk);
    do_reset();

    // coins 5, 2, 1 -> credit 5, 7, 8
    step(1, 2'd2, 0, 0, '0, 0, 0);
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd0, 0, 0, '0, 0, 0);
    // up to 12, then overflow and invalid coin rejects
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd2, 0, 0, '0, 0, 0);
    step(0, 2'd0, 0, 0, '0, 0, 0);
    step(1, 2'd3, 0, 0, '0, 0, 0);
    step(0, 2'd0, 0, 0, '0, 0, 0);

    // vend with change 3
    do_reset();
    step(1, 2'd2, 0, 0, '0, 0, 0);
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd0, 0, 0, '0, 0, 0);
    step(0, 2'd0, 1, 0, '0, 0, 0);
    step(1, 2'd0, 1, 0, '0, 1, 0);
    step(0, 2'd0, 0, 1, N'(3), 0, 1);
    step(0, 2'd0, 0, 0, '0, 0, 0);
    step(0, 2'd0, 0, 0, '0, 0, 1);

    // vend with zero change
    step(1, 2'd2, 0, 0, '0, 0, 0);
    step(1, 2'd0, 0, 0, '0, 0, 0);
    step(0, 2'd0, 1, 0, '0, 0, 0);
    step(0, 2'd0, 0, 1, '0, 0, 0);
    step(0, 2'd0, 0, 0, '0, 0, 0);

    // timeout refund of 2
    step(1, 2'd1, 0, 0, '0, 0, 0);
    idle_steps(TO);
    step(0, 2'd0, 0, 0, '0, 0, 1);
    // coin on the terminal-count cycle keeps collecting
    step(1, 2'd1, 0, 0, '0, 0, 0);
    idle_steps(TO - 1);
    step(1, 2'd0, 0, 0, '0, 0, 0);
    idle_steps(3);
    step(0, 2'd0, 0, 0, '0, 1, 0);
    step(0, 2'd0, 0, 0, '0, 0, 1);

    // cancel with a coin in the same cycle, then reset during refund
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd1, 0, 0, '0, 0, 0);
    step(1, 2'd1, 0, 0, '0, 1, 0);
    step(0, 2'd0, 0, 0, '0, 0, 0);
    do_reset();
    step(0, 2'd0, 0, 0, '0, 0, 0);

    // randomized traffic
    pc = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: pc = 4;
          1: pc = 30;
          default: pc = 75;
        endcase
      end
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < pc, 2'($urandom_range(0, 3)),
             $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 20,
             N'($urandom_range(0, MAXC)), $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 40);
      end
    end

    // drain back to IDLE
    repeat (3) step(0, 2'd0, 0, 1, '0, 1, 1);
    idle_steps(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (eq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs and %0d refunds pending, expected 0 and 0",
               eq.size(), rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
